// File: rtl/vga_object_animator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_object_animator_if
//  Description : Pixel-side bundle between the VGA controller and the object
//                animator: pixel strobe, run control, coordinates, RGB and
//                the per-frame tick.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_object_animator_if;
   logic       enable;
   logic       run;
   logic [9:0] pixel_X_pos;
   logic [9:0] pixel_Y_pos;
   logic [7:0] VGA_red;
   logic [7:0] VGA_green;
   logic [7:0] VGA_blue;
   logic       frame_tick;

   // Side that supplies coordinates and consumes colour (VGA controller / top).
   modport master (
      output enable, run, pixel_X_pos, pixel_Y_pos,
      input  VGA_red, VGA_green, VGA_blue, frame_tick
   );

   // Side that consumes coordinates and produces colour (the animator).
   modport slave (
      input  enable, run, pixel_X_pos, pixel_Y_pos,
      output VGA_red, VGA_green, VGA_blue, frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/vga_object_animator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_object_animator
//  Description : Draws NUM_OBJ coloured squares on one horizontal band. Each
//                square bounces between the screen edges at its own speed,
//                updated once per frame; colour comes from a registered
//                highest-index-wins priority mux.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_object_animator #(
   parameter int NUM_OBJ  = 7,
   parameter int OBJ_SIZE = 40,
   parameter int OBJ_GAP  = 10,
   parameter int ROW_Y    = 220,
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int STEP     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   vga_object_animator_if.slave  bus
);

   // 11-bit arithmetic throughout so x + speed and x + size never wrap.
   localparam logic [10:0] XMAX     = 11'(H_RES - OBJ_SIZE);
   localparam logic [10:0] SIZE_W   = 11'(OBJ_SIZE);
   localparam logic [10:0] BAND_TOP = 11'(ROW_Y);
   localparam logic [10:0] BAND_END = 11'(ROW_Y + OBJ_SIZE);
   localparam logic [9:0]  LAST_COL = 10'(H_RES - 1);
   localparam logic [9:0]  LAST_ROW = 10'(V_RES - 1);

   // Parameter sanity: the squares must fit on screen and never skip an edge.
   if (NUM_OBJ < 1 || NUM_OBJ > 8) begin : g_chk_num
      $error("NUM_OBJ must be in 1..8");
   end
   if (NUM_OBJ * (OBJ_SIZE + OBJ_GAP) - OBJ_GAP > H_RES) begin : g_chk_width
      $error("initial square row does not fit in H_RES");
   end
   if (ROW_Y + OBJ_SIZE > V_RES) begin : g_chk_height
      $error("square band does not fit in V_RES");
   end
   if (STEP * NUM_OBJ >= H_RES - OBJ_SIZE) begin : g_chk_speed
      $error("fastest square speed must be below XMAX");
   end

   logic [10:0]        x [NUM_OBJ];   // left edge of each square
   logic [NUM_OBJ-1:0] dir;           // 1 = moving left, 0 = moving right
   logic [NUM_OBJ-1:0] hit;
   logic [10:0]        px;
   logic [10:0]        py;
   logic               in_band;
   logic               frame_end;
   logic               frame_tick;
   logic [23:0]        rgb;
   logic [23:0]        rgb_next;

   function automatic logic [10:0] speed_of(input int i);
      return 11'(STEP * (i + 1));
   endfunction

   function automatic logic [10:0] home_of(input int i);
      return 11'(i * (OBJ_SIZE + OBJ_GAP));
   endfunction

   function automatic logic [23:0] palette(input int i);
      case (i % 7)
         0:       return 24'hFFFFFF;
         1:       return 24'hFF00FF;
         2:       return 24'hFFFF00;
         3:       return 24'h00FFFF;
         4:       return 24'h0000FF;
         5:       return 24'h00FF00;
         default: return 24'hFF0000;
      endcase
   endfunction

   assign px        = {1'b0, bus.pixel_X_pos};
   assign py        = {1'b0, bus.pixel_Y_pos};
   assign in_band   = (py >= BAND_TOP) && (py < BAND_END);
   assign frame_end = bus.enable && (bus.pixel_X_pos == LAST_COL) &&
                      (bus.pixel_Y_pos == LAST_ROW);

   // One-clock tick on the clock after the last visible pixel strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
      end
   end

   // Per-frame move and bounce of every square; an exact edge hit bounces.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            x[i]   <= home_of(i);
            dir[i] <= 1'(i % 2);
         end
      end else if (frame_tick && bus.run) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (!dir[i]) begin
               if (x[i] + speed_of(i) >= XMAX) begin
                  x[i]   <= XMAX;
                  dir[i] <= 1'b1;
               end else begin
                  x[i]   <= x[i] + speed_of(i);
               end
            end else begin
               if (x[i] <= speed_of(i)) begin
                  x[i]   <= 11'd0;
                  dir[i] <= 1'b0;
               end else begin
                  x[i]   <= x[i] - speed_of(i);
               end
            end
         end
      end
   end

   // Hit test of the current pixel against every square.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         hit[i] = in_band && (px >= x[i]) && (px < x[i] + SIZE_W);
      end
   end

   // Priority mux: later (higher) indices override earlier ones.
   always_comb begin
      rgb_next = 24'h000000;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (hit[i]) begin
            rgb_next = palette(i);
         end
      end
   end

   // Colour register advances only on pixel strobes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rgb <= 24'h000000;
      end else if (bus.enable) begin
         rgb <= rgb_next;
      end
   end

   assign bus.VGA_red    = rgb[23:16];
   assign bus.VGA_green  = rgb[15:8];
   assign bus.VGA_blue   = rgb[7:0];
   assign bus.frame_tick = frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_object_animator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_object_animator
//  Description : Scoreboard bench. Instance A uses the default 7-square
//                configuration; instance B uses two squares so the long
//                edge-bounce sequences can be hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_object_animator;

   localparam logic [23:0] WHITE   = 24'hFFFFFF;
   localparam logic [23:0] MAGENTA = 24'hFF00FF;
   localparam logic [23:0] CYAN    = 24'h00FFFF;
   localparam logic [23:0] GREEN   = 24'h00FF00;
   localparam logic [23:0] RED     = 24'hFF0000;
   localparam logic [23:0] BLACK   = 24'h000000;

   typedef struct {
      logic [23:0] rgb;
      int          px;
      int          py;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   ticks_a = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #10 clk = ~clk;

   vga_object_animator_if ifa ();
   vga_object_animator_if ifb ();

   vga_object_animator dut_a (
      .clock (clk),
      .reset (rst),
      .bus   (ifa.slave)
   );

   vga_object_animator #(.NUM_OBJ(2)) dut_b (
      .clock (clk),
      .reset (rst),
      .bus   (ifb.slave)
   );

   task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [23:0] rgb_of(input bit sel);
      return sel ? {ifb.VGA_red, ifb.VGA_green, ifb.VGA_blue}
                 : {ifa.VGA_red, ifa.VGA_green, ifa.VGA_blue};
   endfunction

   function automatic logic tick_of(input bit sel);
      return sel ? ifb.frame_tick : ifa.frame_tick;
   endfunction

   // Monitor A: every strobe produces one RGB value, compared against the queue.
   always begin : mon_a
      exp_t e;
      @(posedge clk);
      if (ifa.enable === 1'b1 && rst === 1'b0) begin
         #1;
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected: got %h expected none", rgb_of(1'b0));
         end else begin
            e = qa.pop_front();
            chk($sformatf("a_rgb(%0d,%0d)", e.px, e.py), rgb_of(1'b0), e.rgb);
         end
      end
   end

   // Monitor B: same scheme for the two-square instance.
   always begin : mon_b
      exp_t e;
      @(posedge clk);
      if (ifb.enable === 1'b1 && rst === 1'b0) begin
         #1;
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: got %h expected none", rgb_of(1'b1));
         end else begin
            e = qb.pop_front();
            chk($sformatf("b_rgb(%0d,%0d)", e.px, e.py), rgb_of(1'b1), e.rgb);
         end
      end
   end

   // Count frame_tick pulses on instance A.
   always @(negedge clk) begin
      if (ifa.frame_tick === 1'b1) ticks_a++;
   end

   // One pixel strobe on the selected instance, with its expected colour queued.
   task automatic pix(input bit sel, input int px, input int py, input logic [23:0] exp);
      exp_t e;
      e.rgb = exp;
      e.px  = px;
      e.py  = py;
      @(negedge clk);
      ifa.pixel_X_pos = 10'(px);
      ifa.pixel_Y_pos = 10'(py);
      ifb.pixel_X_pos = 10'(px);
      ifb.pixel_Y_pos = 10'(py);
      if (sel) begin
         qb.push_back(e);
         ifb.enable = 1'b1;
      end else begin
         qa.push_back(e);
         ifa.enable = 1'b1;
      end
      @(negedge clk);
      ifa.enable = 1'b0;
      ifb.enable = 1'b0;
   endtask

   // Frame-end strobe: tick must be high for exactly the following clock.
   task automatic frame(input bit sel);
      chk(sel ? "b_tick_pre" : "a_tick_pre", 24'(tick_of(sel)), 24'd0);
      pix(sel, 639, 479, BLACK);
      chk(sel ? "b_tick_on" : "a_tick_on", 24'(tick_of(sel)), 24'd1);
      @(negedge clk);
      chk(sel ? "b_tick_off" : "a_tick_off", 24'(tick_of(sel)), 24'd0);
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stim
      int t0;
      rst = 1'b1;
      ifa.enable = 1'b0; ifa.run = 1'b0; ifa.pixel_X_pos = '0; ifa.pixel_Y_pos = '0;
      ifb.enable = 1'b0; ifb.run = 1'b1; ifb.pixel_X_pos = '0; ifb.pixel_Y_pos = '0;
      repeat (3) @(negedge clk);
      chk("a_reset_rgb",  rgb_of(1'b0), BLACK);
      chk("a_reset_tick", 24'(tick_of(1'b0)), 24'd0);
      chk("b_reset_rgb",  rgb_of(1'b1), BLACK);
      chk("b_reset_tick", 24'(tick_of(1'b1)), 24'd0);
      rst = 1'b0;

      // Reset layout (A): squares at 0,50,..,300; band rows 220..259.
      pix(0, 0,   220, WHITE);
      pix(0, 50,  220, MAGENTA);
      pix(0, 45,  220, BLACK);
      pix(0, 0,   219, BLACK);
      pix(0, 0,   259, WHITE);
      pix(0, 0,   260, BLACK);
      pix(0, 339, 230, RED);
      pix(0, 340, 230, BLACK);

      // run=0: tick still pulses, positions hold.
      frame(0);
      pix(0, 0, 220, WHITE);

      // Frame end needs enable and the exact last pixel; exactly one tick.
      ifa.run = 1'b1;
      t0 = ticks_a;
      pix(0, 637, 479, BLACK);
      pix(0, 639, 478, BLACK);
      @(negedge clk);
      ifa.pixel_X_pos = 10'd639;
      ifa.pixel_Y_pos = 10'd479;
      repeat (2) @(negedge clk);
      frame(0);
      pix(0, 0, 479, BLACK);
      chk("a_tick_count", 24'(ticks_a - t0), 24'd1);

      // After one update: x0=1, x1=48.
      pix(0, 0,  220, BLACK);
      pix(0, 1,  220, WHITE);
      pix(0, 48, 220, MAGENTA);
      pix(0, 47, 220, BLACK);

      // Frame 60: x0=60, x1=70, x3=88, x5=108 -> overlapping, highest wins.
      repeat (59) frame(0);
      pix(0, 65,  240, WHITE);
      pix(0, 75,  240, MAGENTA);
      pix(0, 95,  240, CYAN);
      pix(0, 110, 240, GREEN);

      // B: square 1 leaves 50 at speed 2, reaches 2 after 24 frames.
      repeat (24) frame(1);
      pix(1, 2, 220, MAGENTA);
      pix(1, 1, 220, BLACK);
      frame(1);                       // x1: 2 <= 2 -> 0, turns right; x0=25
      pix(1, 0,  220, MAGENTA);
      pix(1, 39, 220, MAGENTA);
      pix(1, 40, 220, WHITE);
      frame(1);                       // x1 = 2
      pix(1, 1, 220, BLACK);
      pix(1, 2, 220, MAGENTA);
      repeat (574) frame(1);          // frame 600: x0 = 600 (XMAX), x1 = 50
      pix(1, 599, 220, BLACK);
      pix(1, 600, 220, WHITE);
      pix(1, 639, 220, WHITE);
      frame(1);                       // x0 back to 599, x1 = 48
      pix(1, 598, 220, BLACK);
      pix(1, 599, 220, WHITE);
      pix(1, 48,  220, MAGENTA);
      pix(1, 47,  220, BLACK);

      // Asynchronous reset clears RGB immediately.
      pix(0, 65, 240, WHITE);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("a_async_rgb", rgb_of(1'b0), BLACK);
      @(negedge clk);
      rst = 1'b0;

      // Reset while frame_tick is high: tick drops, pending update is lost.
      @(negedge clk);
      ifa.pixel_X_pos = 10'd639;
      ifa.pixel_Y_pos = 10'd479;
      ifa.enable      = 1'b1;
      qa.push_back('{rgb: BLACK, px: 639, py: 479});
      @(negedge clk);
      ifa.enable = 1'b0;
      chk("a_tick_before_rst", 24'(tick_of(1'b0)), 24'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("a_tick_async", 24'(tick_of(1'b0)), 24'd0);
      chk("a_rgb_async",  rgb_of(1'b0), BLACK);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pix(0, 0,  220, WHITE);
      pix(0, 50, 220, MAGENTA);
      pix(0, 45, 220, BLACK);
      frame(0);
      pix(0, 0, 220, BLACK);
      pix(0, 1, 220, WHITE);

      repeat (4) @(negedge clk);
      chk("a_queue_drained", 24'(qa.size()), 24'd0);
      chk("b_queue_drained", 24'(qb.size()), 24'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
